apb_const_reader: RTL and testbench



---
 rtl/apb_const_reader.sv | 136 +++++++++++++
 tb/tb_apb_const_reader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_const_reader.sv
// apb_const_reader: APB requester that reads NUM_WORDS sequential words and streams them out.
// Optional ACCESS-phase timeout is enabled by defining APB_RDR_TIMEOUT_EN.
`default_nettype none

module apb_const_reader #(
  parameter int          NUM_WORDS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'h1,
  parameter int          TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic [31:0] paddr,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata,
  output logic [31:0] out_data,
  output logic [7:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  logic [2:0] state;
  logic [7:0] count;

`ifdef APB_RDR_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= S_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
`ifdef APB_RDR_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SETUP;
            paddr   <= BASE_ADDR;
            count   <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            psel    <= 1'b1;
            penable <= 1'b0;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
`ifdef APB_RDR_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              out_data  <= prdata;
              out_idx   <= count;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
`ifdef APB_RDR_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= S_FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_OUT: begin
          // Next read is issued only after the buffered word is accepted.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (count == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              count <= count + 8'd1;
              paddr <= paddr + ADDR_STEP;
              psel  <= 1'b1;
              state <= S_SETUP;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_const_reader.sv
// Self-checking bench for apb_const_reader with a behavioural constant-register slave.
`default_nettype none

module tb_apb_const_reader;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, psel, penable;
  logic [31:0] paddr;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] out_data;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;

  // second instance whose first read hits an unmapped slave offset
  logic        start5 = 1'b0;
  logic        busy5, done5, err5, psel5, penable5;
  logic [31:0] paddr5;
  logic        pready5, pslverr5;
  logic [31:0] out_data5;
  logic [7:0]  out_idx5;
  logic        out_valid5;

  int checks = 0;
  int fails  = 0;

  always #5 pclk = ~pclk;

  apb_const_reader u_dut (
    .pclk(pclk), .preset(preset), .start(start), .busy(busy), .done(done), .err(err),
    .psel(psel), .penable(penable), .paddr(paddr), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  apb_const_reader #(.BASE_ADDR(32'h5)) u_dut5 (
    .pclk(pclk), .preset(preset), .start(start5), .busy(busy5), .done(done5), .err(err5),
    .psel(psel5), .penable(penable5), .paddr(paddr5), .pready(pready5), .pslverr(pslverr5),
    .prdata(32'h0), .out_data(out_data5), .out_idx(out_idx5), .out_valid(out_valid5),
    .out_ready(1'b1)
  );

  function automatic logic [31:0] slave_data(input logic [7:0] a);
    case (a)
      8'd0:    return 32'hC90FDAA2;
      8'd1:    return 32'h2168C234;
      8'd2:    return 32'hADF85458;
      8'd3:    return 32'hA2BB4A9A;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural slave: pready after slave_wait extra ACCESS cycles, pslverr on unmapped offsets.
  int   slave_wait = 2;
  bit   slave_hang = 1'b0;
  int   wcnt = 0;
  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end
  assign pready   = psel && penable && !slave_hang && (wcnt == slave_wait);
  assign pslverr  = pready && (paddr[7:0] > 8'd3);
  assign prdata   = pready ? slave_data(paddr[7:0]) : 32'h0;
  assign pready5  = psel5 && penable5;
  assign pslverr5 = pready5 && (paddr5[7:0] > 8'd3);

  // Scoreboard and monitors
  logic [39:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [39:0] got;
  logic [39:0] want;
  int done_cnt = 0;
  int done5_cnt = 0;
  bit ov5_seen = 1'b0;

  always @(negedge pclk) begin
    if (!preset) begin
      if (out_valid && out_ready) begin
        got = {out_idx, out_data};
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL word_unexpected: got idx=%0d data=%h, none expected", out_idx, out_data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL word: got idx=%0d data=%h, want idx=%0d data=%h",
                     got[39:32], got[31:0], want[39:32], want[31:0]);
          end
        end
      end
      if (done) done_cnt++;
      if (done5) done5_cnt++;
      if (out_valid5) ov5_seen = 1'b1;
      if (psel && !penable) addr_q.push_back(paddr);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_burst();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), slave_data(8'(i))});
  endtask

  // Returns number of negedges until done is seen (or budget on expiry).
  task automatic wait_done(input int budget, input string name, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge pclk);
      n++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected words not delivered, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) tick();
    @(negedge pclk);
    checks++;
    if ({psel, penable, busy, done, err, out_valid} !== 6'b0 || paddr !== 32'h0 ||
        out_data !== 32'h0 || out_idx !== 8'h0) begin
      fails++;
      $display("FAIL reset_values: got psel=%b pen=%b busy=%b done=%b err=%b ov=%b paddr=%h data=%h idx=%h, want all 0",
               psel, penable, busy, done, err, out_valid, paddr, out_data, out_idx);
    end
    tick();
    preset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_latency();
    int n;
    slave_wait = 0;
    out_ready  = 1'b1;
    done_cnt   = 0;
    push_burst();
    pulse_start();
    wait_done(60, "zero_wait", n);
    checks++;
    if (n !== 13) begin
      fails++;
      $display("FAIL zero_wait_latency: got %0d cycles start-to-done, want 13", n);
    end
    repeat (3) tick();
    check_drained("zero_wait");
    slave_wait = 2;
  endtask

  task automatic test_basic_burst();
    int n;
    logic [31:0] a;
    done_cnt = 0;
    addr_q.delete();
    push_burst();
    pulse_start();
    wait_done(100, "basic", n);
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL basic_err: got %b, want 0", err);
    end
    repeat (4) tick();
    check_drained("basic");
    checks++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL basic_done_count: got %0d, want 1", done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_idle: got %b, want 0", busy);
    end
    checks++;
    if (addr_q.size() != 4) begin
      fails++;
      $display("FAIL basic_addr_count: got %0d setup phases, want 4", addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        a = addr_q[i];
        checks++;
        if (a !== 32'(i)) begin
          fails++;
          $display("FAIL basic_paddr: read %0d got %h, want %h", i, a, 32'(i));
        end
      end
    end
  endtask

  task automatic test_stall();
    int n;
    bit ok;
    done_cnt  = 0;
    out_ready = 1'b0;
    push_burst();
    pulse_start();
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      fails++;
      $display("FAIL stall_first_word: out_valid got 0 after %0d cycles, want 1", n);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (out_valid !== 1'b1 || out_data !== 32'hC90FDAA2 || out_idx !== 8'd0 || psel !== 1'b0) begin
        if (ok) $display("FAIL stall_hold: cycle %0d got ov=%b data=%h idx=%0d psel=%b, want 1/C90FDAA2/0/0",
                         i, out_valid, out_data, out_idx, psel);
        ok = 1'b0;
      end
    end
    checks++;
    if (!ok) fails++;
    tick();
    out_ready = 1'b1;
    wait_done(100, "stall", n);
    repeat (3) tick();
    check_drained("stall");
    checks++;
    if (done_cnt !== 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL stall_finish: got done_cnt=%0d err=%b, want 1/0", done_cnt, err);
    end
  endtask

  task automatic test_slverr();
    int n;
    done5_cnt = 0;
    ov5_seen  = 1'b0;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    n = 0;
    while (!done5 && n < 30) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (done5 !== 1'b1 || err5 !== 1'b1) begin
      fails++;
      $display("FAIL slverr_done_err: got done=%b err=%b, want 1/1", done5, err5);
    end
    repeat (3) tick();
    checks++;
    if (ov5_seen || busy5 !== 1'b0 || err5 !== 1'b1 || done5_cnt !== 1) begin
      fails++;
      $display("FAIL slverr_after: got ov_seen=%b busy=%b err=%b done_cnt=%0d, want 0/0/1/1",
               ov5_seen, busy5, err5, done5_cnt);
    end
  endtask

  task automatic test_hang();
    int n;
    int acc;
    done_cnt   = 0;
    slave_hang = 1'b1;
    pulse_start();
    n = 0;
    while (!(psel && penable) && n < 10) begin
      @(negedge pclk);
      n++;
    end
`ifdef APB_RDR_TIMEOUT_EN
    acc = 0;
    n = 0;
    while (!done && n < 200) begin
      if (psel && penable) acc++;
      @(negedge pclk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || psel !== 1'b0 || acc !== 16) begin
      fails++;
      $display("FAIL timeout_abort: got done=%b err=%b psel=%b access_cycles=%0d, want 1/1/0/16",
               done, err, psel, acc);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_idle: got busy=%b done_cnt=%0d, want 0/1", busy, done_cnt);
    end
`else
    acc = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge pclk);
      if (psel && penable && !done) acc++;
    end
    checks++;
    if (acc !== 110 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hang_wait: got %0d of 110 ACCESS cycles busy=%b, want 110/1", acc, busy);
    end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    tick();
`endif
    slave_hang = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int n;
    done_cnt = 0;
    push_burst();
    pulse_start();
    n = 0;
    while (!(psel && penable && paddr == 32'd2) && n < 60) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (!(psel && penable && paddr == 32'd2)) begin
      fails++;
      $display("FAIL midreset_reach: ACCESS of word 2 not seen, got paddr=%h", paddr);
    end
    preset = 1'b1;
    tick();
    checks++;
    if ({psel, penable, busy, done, err, out_valid} !== 6'b0 || paddr !== 32'h0 ||
        out_data !== 32'h0 || out_idx !== 8'h0) begin
      fails++;
      $display("FAIL midreset_values: got psel=%b pen=%b busy=%b done=%b err=%b ov=%b paddr=%h data=%h idx=%h, want all 0",
               psel, penable, busy, done, err, out_valid, paddr, out_data, out_idx);
    end
    preset = 1'b0;
    exp_q.delete();
    tick();
    checks++;
    if (done_cnt !== 0) begin
      fails++;
      $display("FAIL midreset_no_done: got %0d done pulses, want 0", done_cnt);
    end
    push_burst();
    pulse_start();
    wait_done(100, "midreset_rerun", n);
    repeat (3) tick();
    check_drained("midreset_rerun");
  endtask

  task automatic test_back_to_back();
    int n;
    done_cnt = 0;
    push_burst();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_done(100, "b2b", n);
    repeat (20) tick();
    check_drained("b2b");
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_single_burst: got done_cnt=%0d busy=%b, want 1/0", done_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_latency();
    test_basic_burst();
    test_stall();
    test_slverr();
    test_hang();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
